// File: rtl/count_checker_if.sv
// Bundle of sample-input, event-FIFO and status signals for count_checker.
// clk and rst stay outside the interface as plain ports.
interface count_checker_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_WIDTH = 16
);
    logic                 in_valid;
    logic [WIDTH-1:0]     in_count;
    logic                 in_restart;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [WIDTH-1:0]     evt_expected;
    logic [WIDTH-1:0]     evt_actual;
    logic [ERR_WIDTH-1:0] err_count;
    logic                 locked;
    logic                 overflow;

    // Side that feeds samples and consumes event records.
    modport master (
        output in_valid, in_count, in_restart, evt_ready,
        input  evt_valid, evt_expected, evt_actual, err_count, locked, overflow
    );

    // The checker itself.
    modport slave (
        input  in_valid, in_count, in_restart, evt_ready,
        output evt_valid, evt_expected, evt_actual, err_count, locked, overflow
    );
endinterface

// File: rtl/count_checker.sv
// Sequence checker for a free-running counter: every valid sample must equal
// the previous one plus one (mod 2^WIDTH). Discontinuities bump a saturating
// error counter and queue an {expected, actual} record in a small FIFO that
// drains through a ready/valid port. All outputs come straight from registers.
module count_checker #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ERR_WIDTH = 16
) (
    input logic            clk,
    input logic            rst,
    count_checker_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = 2 * WIDTH;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     last_reg, last_next;
    logic [WIDTH-1:0]     expected;
    logic                 mismatch;
    logic [ERR_WIDTH-1:0] err_reg;
    logic                 overflow_reg;

    // Event FIFO: storage array plus a registered head stage so the record
    // outputs never depend combinationally on evt_ready.
    logic [RW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [AW:0]          fill_reg, fill_next;
    logic                 evt_valid_reg;
    logic [RW-1:0]        head_reg, head_next;
    logic [RW-1:0]        push_rec;
    logic                 full;
    logic                 do_pop;
    logic                 do_push;
    logic                 drop;

    // Next state and mismatch detection; restart wins over a normal check and
    // a sample arriving with the restart becomes the new reference.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        expected   = last_reg + WIDTH'(1);
        mismatch   = 1'b0;
        if (bus.in_restart) begin
            if (bus.in_valid) begin
                state_next = LOCKED;
                last_next  = bus.in_count;
            end else begin
                state_next = UNLOCKED;
            end
        end else if (bus.in_valid) begin
            state_next = LOCKED;
            last_next  = bus.in_count;
            if (state_reg == LOCKED && bus.in_count != expected) begin
                mismatch = 1'b1;
            end
        end
    end

    // State register and reference value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= UNLOCKED;
            last_reg  <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    // Saturating mismatch counter and sticky drop flag; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (mismatch && err_reg != '1) begin
                err_reg <= err_reg + ERR_WIDTH'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // FIFO control: a pop frees a slot in the same cycle, so push+pop while
    // full is accepted. The next head is read from storage, or bypassed from
    // the incoming record when that record becomes the head.
    always_comb begin
        push_rec    = {expected, bus.in_count};
        full        = (fill_reg == (AW+1)'(DEPTH));
        do_pop      = evt_valid_reg && bus.evt_ready;
        do_push     = mismatch && (!full || do_pop);
        drop        = mismatch && full && !do_pop;
        rd_ptr_next = do_pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        wr_ptr_next = do_push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        fill_next   = fill_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        head_next   = head_reg;
        if (fill_next != '0) begin
            if (do_push && rd_ptr_next == wr_ptr_reg) begin
                head_next = push_rec;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    // Record storage; no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_rec;
        end
    end

    // FIFO pointers, fill level and registered head/valid outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            fill_reg      <= '0;
            evt_valid_reg <= 1'b0;
            head_reg      <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            fill_reg      <= fill_next;
            evt_valid_reg <= (fill_next != '0);
            head_reg      <= head_next;
        end
    end

    assign bus.evt_valid    = evt_valid_reg;
    assign bus.evt_expected = head_reg[RW-1:WIDTH];
    assign bus.evt_actual   = head_reg[WIDTH-1:0];
    assign bus.err_count    = err_reg;
    assign bus.locked       = (state_reg == LOCKED);
    assign bus.overflow     = overflow_reg;
endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker with a scoreboard of expected event records.
module tb_count_checker;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 4;
    localparam int ERR_WIDTH = 16;

    logic clk;
    logic rst;

    count_checker_if #(.WIDTH(WIDTH), .ERR_WIDTH(ERR_WIDTH)) bus ();

    count_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERR_WIDTH(ERR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int pops   = 0;

    // Reference model state
    logic [15:0]      sb [$];
    logic             m_locked;
    logic [WIDTH-1:0] m_last;
    int               m_err;
    logic             m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, compare any record popped at this edge,
    // update the model, then advance to just after the edge.
    task automatic step(input logic valid, input logic [WIDTH-1:0] cnt,
                        input logic restart, input logic ready);
        logic             mis;
        logic [WIDTH-1:0] e;
        logic [15:0]      rec;
        bus.in_valid   = valid;
        bus.in_count   = cnt;
        bus.in_restart = restart;
        bus.evt_ready  = ready;
        mis = 1'b0;
        e   = m_last + 8'd1;
        rec = {e, cnt};
        if (restart) begin
            if (valid) begin
                m_last   = cnt;
                m_locked = 1'b1;
            end else begin
                m_locked = 1'b0;
            end
        end else if (valid) begin
            if (m_locked && cnt != e) begin
                mis = 1'b1;
                m_err++;
            end
            m_last   = cnt;
            m_locked = 1'b1;
        end
        @(negedge clk);
        if (bus.evt_valid && bus.evt_ready) begin
            pops++;
            if (sb.size() == 0) begin
                check("evt_spurious", {31'b0, bus.evt_valid}, 32'd0);
            end else begin
                check("evt_record", {16'b0, bus.evt_expected, bus.evt_actual}, {16'b0, sb.pop_front()});
            end
        end
        if (mis) begin
            if (sb.size() < DEPTH) sb.push_back(rec);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_count   = '0;
        bus.in_restart = 1'b0;
        bus.evt_ready  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_locked = 1'b0;
        m_last   = '0;
        m_err    = 0;
        m_ovf    = 1'b0;
        sb.delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_err"}, {16'b0, bus.err_count}, m_err);
        check({tag, "_ovf"}, {31'b0, bus.overflow}, {31'b0, m_ovf});
        check({tag, "_locked"}, {31'b0, bus.locked}, {31'b0, m_locked});
        check({tag, "_valid"}, {31'b0, bus.evt_valid}, {31'b0, (sb.size() != 0)});
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        do_reset();

        // Reset values
        check("rst_valid", {31'b0, bus.evt_valid}, 32'd0);
        check("rst_expected", {24'b0, bus.evt_expected}, 32'd0);
        check("rst_actual", {24'b0, bus.evt_actual}, 32'd0);
        check("rst_err", {16'b0, bus.err_count}, 32'd0);
        check("rst_locked", {31'b0, bus.locked}, 32'd0);
        check("rst_ovf", {31'b0, bus.overflow}, 32'd0);

        // Clean ramp 0..20
        step(1'b1, 8'd0, 1'b0, 1'b1);
        check("ramp_locked_first", {31'b0, bus.locked}, 32'd1);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b1);
            check("ramp_no_evt", {31'b0, bus.evt_valid}, 32'd0);
        end
        check("ramp_err", {16'b0, bus.err_count}, 32'd0);

        // Wrap-around 253..1 after a restart onto 253
        step(1'b1, 8'd253, 1'b1, 1'b1);
        step(1'b1, 8'd254, 1'b0, 1'b1);
        step(1'b1, 8'd255, 1'b0, 1'b1);
        step(1'b1, 8'd0,   1'b0, 1'b1);
        step(1'b1, 8'd1,   1'b0, 1'b1);
        check("wrap_err", {16'b0, bus.err_count}, 32'd0);
        check("wrap_no_evt", {31'b0, bus.evt_valid}, 32'd0);

        // Single skip 5,6,8,9
        p0 = pops;
        step(1'b1, 8'd5, 1'b1, 1'b1);
        step(1'b1, 8'd6, 1'b0, 1'b1);
        step(1'b1, 8'd8, 1'b0, 1'b1);
        check("skip_valid", {31'b0, bus.evt_valid}, 32'd1);
        check("skip_head", {16'b0, bus.evt_expected, bus.evt_actual}, {16'b0, 8'd7, 8'd8});
        step(1'b1, 8'd9, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check("skip_err", {16'b0, bus.err_count}, 32'd1);
        check("skip_pops", pops - p0, 32'd1);
        check_status("skip");

        // Overflow: six mismatches with the consumer stalled
        do_reset();
        step(1'b1, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 8'(2 * i), 1'b0, 1'b0);
        end
        check("ovf_valid", {31'b0, bus.evt_valid}, 32'd1);
        check("ovf_flag", {31'b0, bus.overflow}, 32'd1);
        check("ovf_err", {16'b0, bus.err_count}, 32'd6);
        check("ovf_head", {16'b0, bus.evt_expected, bus.evt_actual}, {16'b0, 8'd1, 8'd2});
        p0 = pops;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'd0, 1'b0, 1'b1);
        end
        check("ovf_pops", pops - p0, 32'd4);
        check("ovf_drained", {31'b0, bus.evt_valid}, 32'd0);
        check_status("ovf");

        // Restart mid-stream: 10,11, restart with 0, then 1,2
        p0 = pops;
        step(1'b1, 8'd10, 1'b1, 1'b1);
        step(1'b1, 8'd11, 1'b0, 1'b1);
        step(1'b1, 8'd0,  1'b1, 1'b1);
        check("rs_locked", {31'b0, bus.locked}, 32'd1);
        step(1'b1, 8'd1,  1'b0, 1'b1);
        step(1'b1, 8'd2,  1'b0, 1'b1);
        check("rs_err", {16'b0, bus.err_count}, 32'd6);
        check("rs_no_evt", {31'b0, bus.evt_valid}, 32'd0);
        check("rs_pops", pops - p0, 32'd0);

        // Restart without a sample drops lock
        step(1'b0, 8'd0, 1'b1, 1'b1);
        check("rs_unlock", {31'b0, bus.locked}, 32'd0);

        // Push and pop together while full
        do_reset();
        step(1'b1, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'(2 * i), 1'b0, 1'b0);
        end
        p0 = pops;
        step(1'b1, 8'd10, 1'b0, 1'b1);
        step(1'b0, 8'd0, 1'b0, 1'b0);
        check("pp_pop", pops - p0, 32'd1);
        check("pp_valid", {31'b0, bus.evt_valid}, 32'd1);
        check("pp_ovf", {31'b0, bus.overflow}, 32'd0);
        check("pp_head", {16'b0, bus.evt_expected, bus.evt_actual}, {16'b0, 8'd3, 8'd4});
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'd0, 1'b0, 1'b1);
        end
        check("pp_pops_total", pops - p0, 32'd5);
        check_status("pp");

        // Reset with three records queued
        do_reset();
        step(1'b1, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 8'(2 * i), 1'b0, 1'b0);
        end
        check("rq_valid_before", {31'b0, bus.evt_valid}, 32'd1);
        check("rq_err_before", {16'b0, bus.err_count}, 32'd3);
        do_reset();
        check("rq_valid", {31'b0, bus.evt_valid}, 32'd0);
        check("rq_err", {16'b0, bus.err_count}, 32'd0);
        check("rq_locked", {31'b0, bus.locked}, 32'd0);
        check("rq_ovf", {31'b0, bus.overflow}, 32'd0);
        step(1'b0, 8'd0, 1'b0, 1'b1);
        check("rq_stays_empty", {31'b0, bus.evt_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
